// File: rtl/cpu_ahb_master.sv
// cpu_ahb_master
//   Bridges a simple CPU single-transfer request into one AHB NONSEQ transfer.
//   The CPU holds cpu_req until cpu_done. The master requests the bus,
//   issues the address phase, waits out the data phase and then pulses cpu_done
//   for one cycle. RETRY/SPLIT responses re-arbitrate and reissue the same
//   transfer. ERROR completes with cpu_err set.
//
// Configuration macro:
//   AHB_TIMEOUT_EN  when defined, a data phase that has HREADY low for
//                   TIMEOUT_CYCLES cycles is abandoned and completes with cpu_err.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cpu_req/cpu_write/cpu_addr/cpu_wdata/cpu_size   CPU request side
//   cpu_stall/cpu_done/cpu_rdata/cpu_err            CPU response side
//   HBUSREQ/HGRANT              arbitration
//   HTRANS/HADDR/HWRITE/HSIZE/HWDATA                AHB address/control/write data
//   HREADY/HRESP/HRDATA         AHB slave response
module cpu_ahb_master #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int AHB_SIZE_BITS  = 3,
  parameter int AHB_TRANS_BITS = 2,
  parameter int AHB_RESP_BITS  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_req,
  input  logic                      cpu_write,
  input  logic [31:0]               cpu_addr,
  input  logic [31:0]               cpu_wdata,
  input  logic [AHB_SIZE_BITS-1:0]  cpu_size,
  output logic                      cpu_stall,
  output logic                      cpu_done,
  output logic [31:0]               cpu_rdata,
  output logic                      cpu_err,
  output logic                      HBUSREQ,
  output logic [AHB_TRANS_BITS-1:0] HTRANS,
  output logic [31:0]               HADDR,
  output logic                      HWRITE,
  output logic [AHB_SIZE_BITS-1:0]  HSIZE,
  output logic [31:0]               HWDATA,
  input  logic                      HGRANT,
  input  logic                      HREADY,
  input  logic [AHB_RESP_BITS-1:0]  HRESP,
  input  logic [31:0]               HRDATA
);

  localparam logic [AHB_TRANS_BITS-1:0] TRANS_IDLE   = AHB_TRANS_BITS'(0);
  localparam logic [AHB_TRANS_BITS-1:0] TRANS_NONSEQ = AHB_TRANS_BITS'(2);
  localparam logic [AHB_RESP_BITS-1:0]  RESP_OKAY    = AHB_RESP_BITS'(0);
  localparam logic [AHB_RESP_BITS-1:0]  RESP_ERROR   = AHB_RESP_BITS'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ADDR,
    S_DATA,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  logic [31:0]              addr_q;
  logic [31:0]              wdata_q;
  logic                     write_q;
  logic [AHB_SIZE_BITS-1:0] size_q;
  logic [31:0]              rdata_q;
  logic                     err_q;
  logic                     to_hit;

`ifdef AHB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  // Counts HREADY-low data cycles; idle outside DATA so every entry starts at 0.
  always_ff @(posedge clk) begin
    if (rst || state != S_DATA) begin
      to_cnt <= '0;
    end else if (!HREADY) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Fires on the wait cycle that would be the TIMEOUT_CYCLES-th.
  assign to_hit = !HREADY && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  // Watchdog compiled out: the data phase waits for HREADY indefinitely.
  assign to_hit = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Captured request and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == S_IDLE && cpu_req) begin
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
        write_q <= cpu_write;
        size_q  <= cpu_size;
      end
      if (state == S_DATA) begin
        if (HREADY && HRESP == RESP_OKAY) begin
          rdata_q <= write_q ? 32'h0 : HRDATA;
          err_q   <= 1'b0;
        end else if ((HREADY && HRESP == RESP_ERROR) || to_hit) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_err   = err_q;

  always_comb begin
    state_nxt = state;
    cpu_stall = 1'b0;
    cpu_done  = 1'b0;
    HBUSREQ   = 1'b0;
    HTRANS    = TRANS_IDLE;
    HADDR     = '0;
    HWRITE    = 1'b0;
    HSIZE     = '0;
    HWDATA    = '0;
    case (state)
      S_IDLE: begin
        cpu_stall = cpu_req;
        if (cpu_req) state_nxt = S_REQ;
      end
      S_REQ: begin
        cpu_stall = 1'b1;
        HBUSREQ   = 1'b1;
        HADDR     = addr_q;
        HWRITE    = write_q;
        HSIZE     = size_q;
        if (HGRANT && HREADY) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        cpu_stall = 1'b1;
        HBUSREQ   = 1'b1;
        HTRANS    = TRANS_NONSEQ;
        HADDR     = addr_q;
        HWRITE    = write_q;
        HSIZE     = size_q;
        if (HREADY) state_nxt = S_DATA;
        else if (!HGRANT) state_nxt = S_REQ;
      end
      S_DATA: begin
        cpu_stall = 1'b1;
        HADDR     = addr_q;
        HWRITE    = write_q;
        HSIZE     = size_q;
        HWDATA    = write_q ? wdata_q : 32'h0;
        if (HREADY) begin
          // RETRY and SPLIT re-arbitrate and replay the captured transfer.
          if (HRESP == RESP_OKAY || HRESP == RESP_ERROR) state_nxt = S_RESP;
          else state_nxt = S_REQ;
        end else if (to_hit) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        cpu_done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_ahb_master.sv
// Directed bench for cpu_ahb_master: reset, read, write with wait states,
// delayed grant, RETRY replay, ERROR completion, reset mid-transfer and the
// optional data-phase timeout.
module tb_cpu_ahb_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic        cpu_write;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [2:0]  cpu_size;
  logic        cpu_stall;
  logic        cpu_done;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic        HBUSREQ;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HGRANT;
  logic        HREADY;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cpu_ahb_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_size(cpu_size),
    .cpu_stall(cpu_stall), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .cpu_err(cpu_err),
    .HBUSREQ(HBUSREQ), .HTRANS(HTRANS), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HGRANT(HGRANT), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] sz);
    cpu_req   = 1'b1;
    cpu_write = wr;
    cpu_addr  = a;
    cpu_wdata = wd;
    cpu_size  = sz;
  endtask

  initial begin
    int n;
    rst = 1'b1; cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cpu_size = '0; HGRANT = 1'b1; HREADY = 1'b1; HRESP = 2'b00; HRDATA = '0;
    tick(); tick();
    chk("rst_done",    {31'b0, cpu_done},  0);
    chk("rst_busreq",  {31'b0, HBUSREQ},   0);
    chk("rst_htrans",  {30'b0, HTRANS},    0);
    chk("rst_haddr",   HADDR,              0);
    chk("rst_hwdata",  HWDATA,             0);
    chk("rst_rdata",   cpu_rdata,          0);
    chk("rst_err",     {31'b0, cpu_err},   0);
    chk("rst_stall",   {31'b0, cpu_stall}, 0);
    rst = 1'b0;
    tick();

    // Read with grant and ready, done in the fourth cycle
    start(1'b0, 32'h0000_0010, 32'h0, 3'd2);
    HRDATA = 32'hDEAD_BEEF;
    #1 chk("rd_idle_stall", {31'b0, cpu_stall}, 1);
    tick();
    chk("rd_req_busreq", {31'b0, HBUSREQ}, 1);
    chk("rd_req_htrans", {30'b0, HTRANS}, 0);
    chk("rd_req_haddr",  HADDR, 32'h10);
    tick();
    chk("rd_addr_htrans", {30'b0, HTRANS}, 2);
    chk("rd_addr_haddr",  HADDR, 32'h10);
    chk("rd_addr_hsize",  {29'b0, HSIZE}, 2);
    chk("rd_addr_hwrite", {31'b0, HWRITE}, 0);
    tick();
    chk("rd_data_htrans", {30'b0, HTRANS}, 0);
    chk("rd_data_busreq", {31'b0, HBUSREQ}, 0);
    chk("rd_data_hwdata", HWDATA, 0);
    chk("rd_data_done",   {31'b0, cpu_done}, 0);
    tick();
    chk("rd_done",  {31'b0, cpu_done}, 1);
    chk("rd_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("rd_err",   {31'b0, cpu_err}, 0);
    chk("rd_stall", {31'b0, cpu_stall}, 0);
    chk("rd_resp_haddr", HADDR, 0);
    cpu_req = 1'b0;
    tick();
    chk("rd_after_done", {31'b0, cpu_done}, 0);

    // Write with three HREADY-low data cycles, done in cycle 7
    start(1'b1, 32'h0000_0020, 32'h1234_5678, 3'd2);
    tick();
    tick();
    chk("wr_addr_hwrite", {31'b0, HWRITE}, 1);
    tick();
    HREADY = 1'b0;
    chk("wr_hwdata_c3", HWDATA, 32'h1234_5678);
    tick();
    chk("wr_hwdata_c4", HWDATA, 32'h1234_5678);
    tick();
    chk("wr_hwdata_c5", HWDATA, 32'h1234_5678);
    chk("wr_wait_done", {31'b0, cpu_done}, 0);
    tick();
    chk("wr_hwdata_c6", HWDATA, 32'h1234_5678);
    HREADY = 1'b1;
    tick();
    chk("wr_done_c7", {31'b0, cpu_done}, 1);
    chk("wr_err",     {31'b0, cpu_err}, 0);
    chk("wr_rdata",   cpu_rdata, 0);
    cpu_req = 1'b0;
    tick();

    // Grant withheld for five cycles
    HGRANT = 1'b0;
    start(1'b0, 32'h0000_0030, 32'h0, 3'd1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("gnt_wait%0d_busreq", i), {31'b0, HBUSREQ}, 1);
      chk($sformatf("gnt_wait%0d_htrans", i), {30'b0, HTRANS}, 0);
    end
    HGRANT = 1'b1;
    tick();
    chk("gnt_addr_htrans", {30'b0, HTRANS}, 2);
    chk("gnt_addr_haddr",  HADDR, 32'h30);
    tick();
    tick();
    chk("gnt_done", {31'b0, cpu_done}, 1);
    cpu_req = 1'b0;
    tick();

    // RETRY once, then OKAY: the transfer is replayed with a single done
    start(1'b0, 32'h0000_0040, 32'h0, 3'd2);
    HRDATA = 32'hA5A5_0001;
    tick();
    tick();
    chk("rty_addr1_htrans", {30'b0, HTRANS}, 2);
    tick();
    HRESP = 2'b10;
    tick();
    chk("rty_no_done",  {31'b0, cpu_done}, 0);
    chk("rty_busreq",   {31'b0, HBUSREQ}, 1);
    chk("rty_req_htrans", {30'b0, HTRANS}, 0);
    HRESP = 2'b00;
    tick();
    chk("rty_addr2_htrans", {30'b0, HTRANS}, 2);
    chk("rty_addr2_haddr",  HADDR, 32'h40);
    tick();
    chk("rty_data2_done", {31'b0, cpu_done}, 0);
    tick();
    chk("rty_done",  {31'b0, cpu_done}, 1);
    chk("rty_rdata", cpu_rdata, 32'hA5A5_0001);
    cpu_req = 1'b0;
    tick();
    chk("rty_single_done", {31'b0, cpu_done}, 0);

    // ERROR response completes with cpu_err and zero read data
    start(1'b1, 32'h0000_0050, 32'hCAFE_F00D, 3'd2);
    tick();
    tick();
    tick();
    chk("err_hwdata", HWDATA, 32'hCAFE_F00D);
    HRESP = 2'b01;
    tick();
    chk("err_done",  {31'b0, cpu_done}, 1);
    chk("err_err",   {31'b0, cpu_err}, 1);
    chk("err_rdata", cpu_rdata, 0);
    cpu_req = 1'b0;
    HRESP = 2'b00;
    tick();

    // Reset asserted in the data phase aborts without cpu_done
    start(1'b0, 32'h0000_0060, 32'h0, 3'd2);
    HRDATA = 32'h1111_2222;
    tick();
    tick();
    tick();
    chk("rst_mid_in_data", {31'b0, HBUSREQ}, 0);
    rst = 1'b1;
    cpu_req = 1'b0;
    tick();
    chk("rstd_done",   {31'b0, cpu_done}, 0);
    chk("rstd_busreq", {31'b0, HBUSREQ}, 0);
    chk("rstd_htrans", {30'b0, HTRANS}, 0);
    chk("rstd_haddr",  HADDR, 0);
    chk("rstd_hwdata", HWDATA, 0);
    chk("rstd_err",    {31'b0, cpu_err}, 0);
    chk("rstd_rdata",  cpu_rdata, 0);
    chk("rstd_stall",  {31'b0, cpu_stall}, 0);
    rst = 1'b0;
    tick();
    chk("rstd_done2", {31'b0, cpu_done}, 0);
    tick();
    chk("rstd_done3", {31'b0, cpu_done}, 0);

    // HREADY held low in the data phase
    start(1'b0, 32'h0000_0070, 32'h0, 3'd2);
    tick();
    tick();
    tick();
    HREADY = 1'b0;
`ifdef AHB_TIMEOUT_EN
    n = 0;
    while (n < 40 && !cpu_done) begin
      tick();
      n++;
    end
    chk("to_cycles", n, 16);
    chk("to_done",   {31'b0, cpu_done}, 1);
    chk("to_err",    {31'b0, cpu_err}, 1);
    HREADY = 1'b1;
`else
    n = 0;
    repeat (30) begin
      tick();
      if (cpu_done) n++;
    end
    chk("hold_no_done", n, 0);
    chk("hold_stall",   {31'b0, cpu_stall}, 1);
    chk("hold_htrans",  {30'b0, HTRANS}, 0);
    HREADY = 1'b1;
    HRDATA = 32'h0BAD_F00D;
    tick();
    chk("hold_done",  {31'b0, cpu_done}, 1);
    chk("hold_err",   {31'b0, cpu_err}, 0);
    chk("hold_rdata", cpu_rdata, 32'h0BAD_F00D);
`endif
    cpu_req = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
